download_sdram_writer: RTL and testbench

//  Sits directly downstream of the ROM/PRG downloader. Takes its byte-write stream
//  (downloading/wr/addr/data) and buffers it in a small FIFO. Replays each byte to
//  the SDRAM controller's download port over a req/ack handshake, so bursts from
//  the downloader never depend on SDRAM slot timing. Drives busy (holds the CPU in

---
 rtl/download_sdram_writer_pkg.sv | 13 +
 rtl/download_sdram_writer_dl_sync_fifo.sv | 48 ++++
 rtl/download_sdram_writer.sv | 118 +++++++++++
 tb/tb_download_sdram_writer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/download_sdram_writer_pkg.sv
// Shared definitions for the downloader -> SDRAM write path: FSM encodings and
// default geometry used by the downloader, this writer and the SDRAM wrapper.
package download_sdram_writer_pkg;

    localparam int ADDR_W_DEF     = 25;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wr_state_t;

endpackage

// File: rtl/download_sdram_writer_dl_sync_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head; a push into a full
// FIFO is still accepted when a pop happens in the same cycle.
module dl_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/download_sdram_writer.sv
// Buffers the downloader byte stream and replays it to the SDRAM download port
// over req/ack; reports busy, a done pulse once everything is committed, and overflow.
module download_sdram_writer
    import download_sdram_writer_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_downloading,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              sd_req,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_data,
    input  logic              sd_ack,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wr_state_t          state, state_next;
    logic [ADDR_W+7:0]  fifo_dout;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_next;
    logic               load;
    logic               pop;
    logic               accepted;
    logic               drop;
    logic               dl_prev;
    logic               rise;
    logic               fall;
    logic               end_pending;
    logic               end_pending_next;
    logic               done_cond;
    logic               busy_next;

    dl_sync_fifo #(
        .WIDTH (ADDR_W + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (dl_wr),
        .pop     (pop),
        .din     ({dl_addr, dl_data}),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_IDLE: if (!fifo_empty) begin
                load       = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: if (sd_ack) begin
                pop        = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // busy is registered from next-cycle values so it drops on the same edge as done.
    always_comb begin
        rise       = dl_downloading & ~dl_prev;
        fall       = ~dl_downloading & dl_prev;
        accepted   = dl_wr & (~fifo_full | pop);
        drop       = dl_wr & fifo_full & ~pop;
        count_next = fifo_count + CNT_W'(accepted) - CNT_W'(pop);
        done_cond  = end_pending & fifo_empty & (state == ST_IDLE) & ~dl_wr & ~rise;
        end_pending_next = end_pending;
        if (done_cond || rise) end_pending_next = 1'b0;
        else if (fall)         end_pending_next = 1'b1;
        busy_next = dl_downloading | (count_next != '0) |
                    (state_next == ST_WAIT) | end_pending_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd_req      <= 1'b0;
            sd_addr     <= '0;
            sd_data     <= '0;
            dl_prev     <= 1'b0;
            end_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            sd_req      <= (state_next == ST_WAIT);
            if (load) {sd_addr, sd_data} <= fifo_dout;
            dl_prev     <= dl_downloading;
            end_pending <= end_pending_next;
            busy        <= busy_next;
            done        <= done_cond;
            overflow    <= drop | (overflow & ~rise);
        end
    end

endmodule

// File: tb/tb_download_sdram_writer.sv
// Directed bench for download_sdram_writer with a queue-based reference model
// checked every cycle plus hand-computed expectations for each scenario.
module tb_download_sdram_writer;

    localparam int AW = 25;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          dl_downloading = 1'b0;
    logic          dl_wr = 1'b0;
    logic [AW-1:0] dl_addr = '0;
    logic [7:0]    dl_data = '0;
    logic          sd_ack = 1'b0;
    logic          sd_req;
    logic [AW-1:0] sd_addr;
    logic [7:0]    sd_data;
    logic          busy;
    logic          done;
    logic          overflow;

    download_sdram_writer #(.ADDR_W(AW), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dl_downloading (dl_downloading),
        .dl_wr          (dl_wr),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .sd_req         (sd_req),
        .sd_addr        (sd_addr),
        .sd_data        (sd_data),
        .sd_ack         (sd_ack),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int low_run  = 0;
    bit armed    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds every accepted byte not yet acknowledged.
    logic [AW+7:0] mq[$];
    bit m_ovf, m_end, m_done, m_dlprev, m_busy;
    bit req_seen;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_ovf = 0; m_end = 0; m_done = 0; m_dlprev = 0; m_busy = 0;
        end else begin : model_step
            bit m_pop, m_rise, m_fall, m_dc;
            int sz;
            sz     = mq.size();
            m_pop  = sd_ack && req_seen && (sz > 0);
            m_rise = dl_downloading && !m_dlprev;
            m_fall = !dl_downloading && m_dlprev;
            m_dc   = m_end && (sz == 0) && !dl_wr && !m_rise;
            m_done = m_dc;
            if (m_dc || m_rise) m_end = 0;
            else if (m_fall)    m_end = 1;
            if (m_rise) m_ovf = 0;
            if (m_pop) void'(mq.pop_front());
            if (dl_wr) begin
                if (sz < D || m_pop) mq.push_back({dl_addr, dl_data});
                else                 m_ovf = 1;
            end
            m_dlprev = dl_downloading;
            m_busy   = dl_downloading || (mq.size() > 0) || m_end;
        end
    end

    always @(negedge clk) begin
        req_seen = sd_req;
        if (reset_n && armed) begin
            if (done) done_cnt++;
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("done", 64'(done), 64'(m_done));
            chk("busy", 64'(busy), 64'(m_busy));
            if (mq.size() == 0) begin
                low_run = 0;
                chk("idle_req", 64'(sd_req), 64'(0));
            end else if (sd_req) begin
                low_run = 0;
                chk("head", 64'({sd_addr, sd_data}), 64'(mq[0]));
            end else begin
                low_run++;
                chk("req_latency", 64'(low_run > 1), 64'(0));
            end
        end else begin
            low_run = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        dl_wr = 1'b1; dl_addr = a; dl_data = d;
        step();
        dl_wr = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sd_req) begin ok = 1'b1; break; end
            step();
        end
        chk("req_timeout", 64'(ok), 64'(1));
    endtask

    task automatic ack_after(input int dly, output logic [AW+7:0] seen);
        bit ok;
        wait_req(ok);
        seen = {sd_addr, sd_data};
        repeat (dly) step();
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
    endtask

    logic [AW+7:0] s;
    int d0;
    bit ok;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 64'(sd_req), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_addr", 64'(sd_addr), 64'(0));
        chk("rst_data", 64'(sd_data), 64'(0));
        reset_n = 1'b1;
        armed   = 1'b1;
        step(); step();

        // 1: single byte
        dl_addr = '0; dl_data = 8'hF3; dl_wr = 1'b1;
        step();
        chk("t1_no_req_yet", 64'(sd_req), 64'(0));
        dl_wr = 1'b0;
        step();
        chk("t1_req", 64'(sd_req), 64'(1));
        chk("t1_addr", 64'(sd_addr), 64'(0));
        chk("t1_data", 64'(sd_data), 64'(8'hF3));
        step(); step();
        chk("t1_held", 64'({sd_req, sd_data}), 64'({1'b1, 8'hF3}));
        sd_ack = 1'b1;
        step();
        sd_ack = 1'b0;
        chk("t1_req_drop", 64'(sd_req), 64'(0));
        chk("t1_busy", 64'(busy), 64'(0));
        step();

        // 2: PRG tail after downloading falls
        dl_downloading = 1'b1; step(); step();
        dl_downloading = 1'b0; step();
        d0 = done_cnt;
        wr(25'h103E9, 8'hA0);
        wr(25'h103EA, 8'h89);
        ack_after(5, s);
        chk("t2_first", 64'(s), 64'({25'h103E9, 8'hA0}));
        chk("t2_no_early_done", 64'(done_cnt - d0), 64'(0));
        ack_after(5, s);
        chk("t2_second", 64'(s), 64'({25'h103EA, 8'h89}));
        repeat (4) step();
        chk("t2_done_once", 64'(done_cnt - d0), 64'(1));
        chk("t2_busy", 64'(busy), 64'(0));

        // 3: overflow with ack withheld
        dl_downloading = 1'b1; step();
        for (int i = 0; i < 10; i++) wr(25'(32'h200 + i), 8'(i));
        chk("t3_ovf_set", 64'(overflow), 64'(1));
        for (int i = 0; i < 8; i++) begin
            ack_after(1, s);
            chk("t3_order", 64'(s), 64'({25'(32'h200 + i), 8'(i)}));
        end
        repeat (3) step();
        chk("t3_drained", 64'(sd_req), 64'(0));
        dl_downloading = 1'b0; repeat (4) step();
        chk("t3_ovf_sticky", 64'(overflow), 64'(1));
        dl_downloading = 1'b1; step();
        chk("t3_ovf_clear", 64'(overflow), 64'(0));

        // 4: full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) wr(25'(32'h300 + i), 8'(8'h10 + i));
        chk("t4_req", 64'(sd_req), 64'(1));
        sd_ack = 1'b1; dl_wr = 1'b1; dl_addr = 25'h3FF; dl_data = 8'hEE;
        step();
        sd_ack = 1'b0; dl_wr = 1'b0;
        chk("t4_ovf", 64'(overflow), 64'(0));
        for (int i = 0; i < 8; i++) begin
            ack_after(0, s);
            if (i < 7) chk("t4_order", 64'(s), 64'({25'(32'h301 + i), 8'(8'h11 + i)}));
            else       chk("t4_last", 64'(s), 64'({25'h3FF, 8'hEE}));
        end
        step(); step();
        chk("t4_empty", 64'(sd_req), 64'(0));
        dl_downloading = 1'b0; repeat (4) step();

        // 5: spurious ack while idle
        d0 = done_cnt;
        sd_ack = 1'b1; step(); sd_ack = 1'b0; step(); step();
        chk("t5_req", 64'(sd_req), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_done", 64'(done_cnt - d0), 64'(0));

        // 6: reset while a write is pending
        dl_downloading = 1'b1; step();
        for (int i = 0; i < 4; i++) wr(25'(32'h400 + i), 8'(8'h40 + i));
        wait_req(ok);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_req_async", 64'(sd_req), 64'(0));
        d0 = done_cnt;
        dl_downloading = 1'b0;
        step(); step();
        reset_n = 1'b1;
        repeat (4) step();
        chk("t6_req", 64'(sd_req), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_done", 64'(done_cnt - d0), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
